// File: rtl/sub_serial_if.sv
// Start/done handshake and result bundle between the lab controller and the bit-serial subtractor.
interface sub_serial_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, ovf, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, ovf, zero
  );
endinterface

// File: rtl/sub_serial.sv
// Bit-serial subtractor: DIFF = A - B, LSB first, one full-subtractor cell and a registered borrow.
module sub_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  sub_serial_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               bq_q, bq_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic               d_bit;
  logic               b_next;
  logic [WIDTH-1:0]   res_next;

  // Full-subtractor cell on the current LSBs
  assign d_bit    = sa_q[0] ^ sb_q[0] ^ bq_q;
  assign b_next   = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & bq_q);
  assign res_next = {d_bit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    bq_d     = bq_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = RUN;
          sa_d     = bus.a;
          sb_d     = bus.b;
          res_d    = '0;
          bq_d     = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          diff_d   = '0;
          borrow_d = 1'b0;
          ovf_d    = 1'b0;
          zero_d   = 1'b0;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        res_d = res_next;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        bq_d  = b_next;
        cnt_d = cnt_q + CNT_W'(1);
        // On the last bit sa_q[0]/sb_q[0] are the latched operand MSBs
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          diff_d   = res_next;
          borrow_d = b_next;
          ovf_d    = (sa_q[0] ^ sb_q[0]) & (sa_q[0] ^ d_bit);
          zero_d   = (res_next == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      bq_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      bq_q     <= bq_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial: directed vectors, multi-cycle corner sequences, random ops vs. arithmetic model.
module tb_sub_serial;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sub_serial_if #(.WIDTH(W)) bus ();

  sub_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    logic         zero;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: {zero, ovf, borrow, diff}
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    logic         br;
    logic         ov;
    d  = W'((int'(a) - int'(b) + 256) % 256);
    br = (a < b);
    ov = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
    return {(d == 0), ov, br, d};
  endfunction

  // Accept edge follows the first negedge; returns at the negedge right after acceptance.
  task automatic do_start(input logic [W-1:0] aa, input logic [W-1:0] bb);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = aa;
    bus.b     = bb;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  // Counts negedges from the one right after acceptance until done; expects exactly W.
  task automatic wait_done(input bit scramble);
    int k;
    k = 0;
    while (!bus.done && k < int'(W) + 4) begin
      if (bus.busy && bus.done) check("busy_done_overlap", 32'd1, 32'd0);
      if (scramble) begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
      end
      @(negedge clk);
      k++;
    end
    check("latency", 32'(k), 32'(W));
    check("busy_low_at_done", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] ed, input logic eb,
                              input logic eo, input logic ez, input bit check_hold);
    logic [W-1:0] held;
    check({tag, ".diff"},   32'(bus.diff),   32'(ed));
    check({tag, ".borrow"}, 32'(bus.borrow), 32'(eb));
    check({tag, ".ovf"},    32'(bus.ovf),    32'(eo));
    check({tag, ".zero"},   32'(bus.zero),   32'(ez));
    if (check_hold) begin
      held = bus.diff;
      @(negedge clk);
      check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
      check({tag, ".diff_hold"},  32'(bus.diff), 32'(ed));
      if (held !== bus.diff) check({tag, ".diff_stable"}, 32'(bus.diff), 32'(held));
    end
  endtask

  initial begin
    logic [W+2:0] m;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           k;
    total = 0;
    bad   = 0;

    vecs[0] = '{a: 8'h35, b: 8'h12, diff: 8'h23, borrow: 1'b0, ovf: 1'b0, zero: 1'b0};
    vecs[1] = '{a: 8'h12, b: 8'h35, diff: 8'hDD, borrow: 1'b1, ovf: 1'b0, zero: 1'b0};
    vecs[2] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, borrow: 1'b0, ovf: 1'b1, zero: 1'b0};
    vecs[3] = '{a: 8'h7F, b: 8'hFF, diff: 8'h80, borrow: 1'b1, ovf: 1'b1, zero: 1'b0};
    vecs[4] = '{a: 8'h5A, b: 8'h5A, diff: 8'h00, borrow: 1'b0, ovf: 1'b0, zero: 1'b1};
    vecs[5] = '{a: 8'h00, b: 8'h01, diff: 8'hFF, borrow: 1'b1, ovf: 1'b0, zero: 1'b0};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.busy",   32'(bus.busy),   32'd0);
    check("rst.done",   32'(bus.done),   32'd0);
    check("rst.diff",   32'(bus.diff),   32'd0);
    check("rst.borrow", 32'(bus.borrow), 32'd0);
    check("rst.ovf",    32'(bus.ovf),    32'd0);
    check("rst.zero",   32'(bus.zero),   32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      do_start(vecs[i].a, vecs[i].b);
      wait_done(1'b0);
      check_result($sformatf("vec%0d", i), vecs[i].diff, vecs[i].borrow,
                   vecs[i].ovf, vecs[i].zero, 1'b1);
    end

    // Start held high, operands scrambled during RUN, back-to-back restart from DONE
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h01;
    @(negedge clk);
    check("b2b.busy", 32'(bus.busy), 32'd1);
    wait_done(1'b1);
    check_result("b2b.first", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.a = 8'h44;
    bus.b = 8'h11;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b.restart_busy", 32'(bus.busy), 32'd1);
    check("b2b.restart_done", 32'(bus.done), 32'd0);
    wait_done(1'b1);
    check_result("b2b.second", 8'h33, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset during the 4th RUN cycle abandons the operation
    do_start(8'hC3, 8'h21);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst.busy", 32'(bus.busy), 32'd0);
    check("midrst.done", 32'(bus.done), 32'd0);
    check("midrst.diff", 32'(bus.diff), 32'd0);
    k = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) k++;
    end
    check("midrst.no_done", 32'(k), 32'd0);
    do_start(8'hC3, 8'h21);
    wait_done(1'b0);
    m = model(8'hC3, 8'h21);
    check_result("midrst.fresh", m[W-1:0], m[W], m[W+1], m[W+2], 1'b1);

    // Random operations against the arithmetic model, with scrambled inputs during RUN
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 8 == 0) rb = ra;
      m = model(ra, rb);
      do_start(ra, rb);
      wait_done(1'b1);
      check_result($sformatf("rand%0d", i), m[W-1:0], m[W], m[W+1], m[W+2], 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sub_serial.md
Name: sub_serial

Overview:
- Bit-serial subtractor; computes DIFF = A − B, least-significant bit first, one bit per clock.
- Complements the combinational ripple-carry adder: same operand width, but trades area for latency.
- Uses a single full-subtractor cell and a registered borrow.
- Sits beside the adder in the datapath; driven by a start/done handshake from the lab controller.

Parameters:
WIDTH, 8, operand and result width in bits (≥2)

Ports:
clk     input   1      system clock, all logic on rising edge
rst_n   input   1      synchronous active-low reset
start   input   1      request; sampled only when state is IDLE or DONE
a       input   WIDTH  minuend; latched on accepted start
b       input   WIDTH  subtrahend; latched on accepted start
busy    output  1      high while state is RUN
done    output  1      one-cycle pulse; result valid
diff    output  WIDTH  A − B mod 2^WIDTH; held until next accepted start
borrow  output  1      unsigned borrow out (1 when A < B unsigned)
ovf     output  1      signed two's-complement overflow
zero    output  1      1 when diff == 0

Behaviour:
- One clock domain; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - busy, done, diff, borrow, ovf and zero all go to 0.
  - Internal shift registers, borrow flop and bit counter are cleared.
  - Reset applies from any state; an operation in flight is abandoned and produces no done.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - start=1 at an edge latches a→SA and b→SB, clears the borrow flop, sets cnt=0, and moves to RUN.
  - On that same edge, diff, borrow, ovf and zero are cleared to 0.
- RUN, each edge:
  - d = SA[0] ^ SB[0] ^ bq.
  - bq_next = (~SA[0] & SB[0]) | (~(SA[0] ^ SB[0]) & bq).
  - d shifts into the MSB of the result register; SA and SB shift right by one.
  - cnt increments.
  - On the edge where cnt == WIDTH−1, state goes to DONE and the outputs load:
    - diff loads the completed result register.
    - borrow = bq_next.
    - ovf = (a_msb ^ b_msb) & (a_msb ^ d), where a_msb and b_msb are the latched operand MSBs and d is the final result bit.
    - zero = (completed diff == 0).
- DONE:
  - done=1 for exactly this cycle.
  - The next edge returns to IDLE, unless start=1, in which case it accepts the new operands exactly as in IDLE (back-to-back operation).
- Latency: start accepted at edge E → busy=1 from E through E+WIDTH; done=1 in the cycle after edge E+WIDTH. For WIDTH=8, done follows 8 RUN edges.
- Throughput: one result per WIDTH+1 cycles with back-to-back start.
- start during RUN is ignored; operands are not re-latched.
- a and b may change freely after acceptance; only the latched copies are used.
- busy and done are never high together.
- Result outputs are stable from DONE until the next accepted start.
- Width rules:
  - diff is WIDTH bits, modulo 2^WIDTH.
  - borrow is the 1-bit unsigned borrow.
  - No sign extension is performed.
- The bit counter is $clog2(WIDTH) bits wide and must not wrap before WIDTH−1.

Test Plan:
- Reset, then a=0x35, b=0x12, start pulse → done after 8 RUN cycles with diff=0x23, borrow=0, ovf=0, zero=0.
- a=0x12, b=0x35 → diff=0xDD, borrow=1, ovf=0, zero=0.
- a=0x80, b=0x01 → diff=0x7F, borrow=0, ovf=1. Then a=0x7F, b=0xFF → diff=0x80, borrow=1, ovf=1.
- a=0x5A, b=0x5A → diff=0x00, zero=1, borrow=0. Then a=0x00, b=0x01 → diff=0xFF, borrow=1, zero=0.
- start held high with a=0x10, b=0x01, and a, b changed on every cycle during RUN:
  - First result is diff=0x0F.
  - No re-latch occurs during RUN.
  - The back-to-back operation starts in the DONE cycle using the a/b present on that edge.
- rst_n=0 on the 4th RUN cycle → next cycle busy=0, done=0, diff=0. No done pulse follows. A fresh start afterwards completes normally.
